// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Dual-writeback register file with write-to-read bypass and a
//            per-register pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic [ADDR_W:0]   busy_count,
    output logic              wb_conflict
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;
    logic              r_wb_conflict;

    logic              w_wb0_en;
    logic              w_wb1_en;
    logic              w_rsv_en;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_busy_cnt_nxt;

    // Register 0 swallows writes and reservations when hardwired to zero.
    assign w_wb0_en = wb0_valid && !(ZERO_REG && (wb0_addr == '0));
    assign w_wb1_en = wb1_valid && !(ZERO_REG && (wb1_addr == '0));
    assign w_rsv_en = rsv_valid && !(ZERO_REG && (rsv_addr == '0));

    // Writebacks clear first so a same-cycle reservation leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb0_en) w_busy_nxt[wb0_addr] = 1'b0;
        if (w_wb1_en) w_busy_nxt[wb1_addr] = 1'b0;
        if (w_rsv_en) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy        <= '0;
            r_busy_count  <= '0;
            r_wb_conflict <= 1'b0;
        end else begin
            // Port 1 is written last so it wins an address collision.
            if (w_wb0_en) r_regs[wb0_addr] <= wb0_data;
            if (w_wb1_en) r_regs[wb1_addr] <= wb1_data;
            r_busy        <= w_busy_nxt;
            r_busy_count  <= w_busy_cnt_nxt;
            r_wb_conflict <= wb0_valid && wb1_valid && (wb0_addr == wb1_addr);
        end
    end

    function automatic logic [DATA_W-1:0] f_read_data(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        if (ZERO_REG && (addr == '0))             v = '0;
        else if (wb1_valid && (wb1_addr == addr)) v = wb1_data;
        else if (wb0_valid && (wb0_addr == addr)) v = wb0_data;
        else                                      v = r_regs[addr];
        return v;
    endfunction

    function automatic logic f_read_busy(input logic [ADDR_W-1:0] addr);
        return r_busy[addr]
            && !(wb0_valid && (wb0_addr == addr))
            && !(wb1_valid && (wb1_addr == addr));
    endfunction

    assign rd_data_a   = rst ? '0   : f_read_data(rd_addr_a);
    assign rd_data_b   = rst ? '0   : f_read_data(rd_addr_b);
    assign rd_busy_a   = rst ? 1'b0 : f_read_busy(rd_addr_a);
    assign rd_busy_b   = rst ? 1'b0 : f_read_busy(rd_addr_b);
    assign busy_count  = r_busy_count;
    assign wb_conflict = r_wb_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed self-checking bench; drives one stimulus into a
//            ZERO_REG=1 and a ZERO_REG=0 instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b, rsv_addr, wb0_addr, wb1_addr;
    logic        rsv_valid, wb0_valid, wb1_valid;
    logic [31:0] wb0_data, wb1_data;

    logic [31:0] z_data_a, z_data_b, n_data_a, n_data_b;
    logic        z_busy_a, z_busy_b, n_busy_a, n_busy_b;
    logic [5:0]  z_cnt, n_cnt;
    logic        z_conf, n_conf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_dut_z (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(z_data_a), .rd_busy_a(z_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(z_data_b), .rd_busy_b(z_busy_b),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .busy_count(z_cnt), .wb_conflict(z_conf)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) u_dut_n (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(n_data_a), .rd_busy_a(n_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(n_data_b), .rd_busy_b(n_busy_b),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .busy_count(n_cnt), .wb_conflict(n_conf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsv_valid = 1'b0;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0; rsv_addr = '0;
        wb0_addr = '0; wb1_addr = '0; wb0_data = '0; wb1_data = '0;
        idle_inputs();
        step();
        step();

        // Reads are forced to zero while reset is held.
        wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h1234; rd_addr_a = 5'd9;
        #1;
        chk("rst_gate_data", z_data_a, 32'h0);
        idle_inputs();
        rst = 1'b0;
        #1;

        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk("reset_data_a", z_data_a, 32'h0);
            chk("reset_data_b", z_data_b, 32'h0);
            chk("reset_busy_a", 32'(z_busy_a), 32'h0);
            chk("reset_busy_b", 32'(z_busy_b), 32'h0);
        end
        chk("reset_count", 32'(z_cnt), 32'h0);
        chk("reset_conflict", 32'(z_conf), 32'h0);

        // Reserve x5, then fill it from wb1.
        rsv_valid = 1'b1; rsv_addr = 5'd5; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        chk("rsv_same_cycle_busy", 32'(z_busy_a), 32'h0);
        step();
        idle_inputs();
        #1;
        chk("rsv5_busy_a", 32'(z_busy_a), 32'h1);
        chk("rsv5_busy_b", 32'(z_busy_b), 32'h1);
        chk("rsv5_count", 32'(z_cnt), 32'h1);
        wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 32'hDEADBEEF;
        #1;
        chk("wb5_bypass_data", z_data_a, 32'hDEADBEEF);
        chk("wb5_bypass_busy", 32'(z_busy_a), 32'h0);
        step();
        idle_inputs();
        #1;
        chk("wb5_reg_data", z_data_a, 32'hDEADBEEF);
        chk("wb5_reg_busy", 32'(z_busy_a), 32'h0);
        chk("wb5_count", 32'(z_cnt), 32'h0);

        // Both writeback ports hit x7: wb1 wins, conflict pulses once.
        wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h22;
        rd_addr_a = 5'd7;
        #1;
        chk("conf_bypass", z_data_a, 32'h22);
        chk("conf_pre", 32'(z_conf), 32'h0);
        step();
        idle_inputs();
        #1;
        chk("conf_reg_data", z_data_a, 32'h22);
        chk("conf_pulse", 32'(z_conf), 32'h1);
        step();
        chk("conf_clear", 32'(z_conf), 32'h0);
        chk("conf_reg_data2", z_data_a, 32'h22);

        // wb0 alone bypasses when wb1 targets elsewhere.
        wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h33;
        wb1_valid = 1'b1; wb1_addr = 5'd8; wb1_data = 32'h44;
        rd_addr_b = 5'd8;
        #1;
        chk("wb0_bypass", z_data_a, 32'h33);
        chk("wb1_bypass_b", z_data_b, 32'h44);
        step();
        idle_inputs();
        #1;
        chk("no_conf_diff_addr", 32'(z_conf), 32'h0);

        // Reserve and writeback x3 in the same cycle: reservation wins.
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h5;
        rd_addr_a = 5'd3;
        step();
        idle_inputs();
        #1;
        chk("rsvwb3_busy", 32'(z_busy_a), 32'h1);
        chk("rsvwb3_data", z_data_a, 32'h5);
        chk("rsvwb3_count", 32'(z_cnt), 32'h1);
        wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h6;
        step();
        idle_inputs();
        #1;
        chk("wb3_clear_count", 32'(z_cnt), 32'h0);
        chk("wb3_data", z_data_a, 32'h6);

        // Register 0: hardwired in one instance, ordinary in the other.
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFF;
        rd_addr_a = 5'd0;
        #1;
        chk("x0_z_bypass", z_data_a, 32'h0);
        chk("x0_n_bypass", n_data_a, 32'hFF);
        step();
        idle_inputs();
        #1;
        chk("x0_z_data", z_data_a, 32'h0);
        chk("x0_z_busy", 32'(z_busy_a), 32'h0);
        chk("x0_z_count", 32'(z_cnt), 32'h0);
        chk("x0_n_data", n_data_a, 32'hFF);
        chk("x0_n_busy", 32'(n_busy_a), 32'h1);
        chk("x0_n_count", 32'(n_cnt), 32'h1);
        wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'hAB;
        #1;
        chk("x0_n_wb_bypass", n_data_a, 32'hAB);
        chk("x0_n_wb_busy", 32'(n_busy_a), 32'h0);
        step();
        idle_inputs();
        #1;
        chk("x0_n_wb_count", 32'(n_cnt), 32'h0);
        chk("x0_n_wb_data", n_data_a, 32'hAB);

        // Reserve x1..x4, then reset with an in-flight write to x2.
        for (int i = 1; i <= 4; i++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(i);
            step();
        end
        idle_inputs();
        #1;
        chk("rsv4_count", 32'(z_cnt), 32'h4);
        rd_addr_a = 5'd2;
        #1;
        chk("rsv4_busy_x2", 32'(z_busy_a), 32'h1);
        rst = 1'b1;
        wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h99;
        #1;
        chk("rst_mid_data", z_data_a, 32'h0);
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("post_rst_count", 32'(z_cnt), 32'h0);
        chk("post_rst_x2_data", z_data_a, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            rd_addr_b = 5'(i);
            #1;
            chk("post_rst_busy", 32'(z_busy_b), 32'h0);
        end
        rd_addr_a = 5'd7;
        #1;
        chk("post_rst_x7_data", z_data_a, 32'h0);
        chk("post_rst_conflict", 32'(z_conf), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
